butterfly_inverse_pipe: RTL and testbench
=========================================

Name: butterfly_inverse_pipe

Overview:
- Pipelined inverse (IFFT / decimation-in-frequency) radix-2 butterfly.
- Takes the two complex outputs of a forward butterfly plus the twiddle, and recovers the original pair:
  - out1 = (in1 + in2)/2
  - out2 = ((in1 - in2)/2) * conj(W)
- Exact inverse of the forward butterfly for |W| = 1.
- Sits in the IFFT datapath between the stage memory read port and the write-back port.
- Uses a valid/ready stream interface.

Parameters:
- DATA_W, 16: total word width, sign-magnitude (bit DATA_W-1 = sign, remaining bits = magnitude).
- FRAC_W, 8: fractional bits of the magnitude (Q8.8 at defaults).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts a beat this cycle
- input_1_real  in  DATA_W  X real
- input_1_imaginary  in  DATA_W  X imag
- input_2_real  in  DATA_W  Y real
- input_2_imaginary  in  DATA_W  Y imag
- twiddle_real  in  DATA_W  W real
- twiddle_imaginary  in  DATA_W  W imag
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- output_1_real  out  DATA_W  (X+Y)/2 real
- output_1_imaginary  out  DATA_W  (X+Y)/2 imag
- output_2_real  out  DATA_W  ((X-Y)/2)*conj(W) real
- output_2_imaginary  out  DATA_W  ((X-Y)/2)*conj(W) imag

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high (reset).
- Reset: clears all stage valid bits; all data outputs 0x0000; out_valid 0. in_ready is 1 in the first cycle after reset deasserts.
- Reset mid-operation: in-flight beats are discarded, never emitted. Reset overrides in_valid in the same cycle.
- Handshake: a transfer occurs when valid && ready on a clock edge.
  - in_ready = !out_valid || out_ready, so the whole pipeline advances or stalls together.
  - Outputs hold stable while out_valid && !out_ready.
  - in_ready is combinational from out_ready; there is no combinational path from in_valid to out_valid.
- Latency: 3 cycles from accepted input to out_valid with no stall. Throughput 1 beat/cycle.
- S1 (register on accept):
  - Convert all six inputs to (DATA_W+1)-bit two's complement. 0x8000 (negative zero) converts to 0.
  - Compute sum = X+Y and diff = X-Y (DATA_W+2 bits), then arithmetic shift right by 1 (floor).
  - Register sum/2, diff/2 and the twiddle.
- S2:
  - real2 = dr*wr + di*wi
  - imag2 = di*wr - dr*wi
  - Full-precision products; keep bits [FRAC_W + DATA_W-1 : FRAC_W] of the sum (floor), with a saturation flag.
  - Pass sum/2 through.
- S3: convert to sign-magnitude.
  - Magnitude > 2^(DATA_W-1)-1 saturates to 0x7FFF / 0xFFFF by sign.
  - Result 0 is always emitted as 0x0000, never 0x8000.
- out1 never overflows, because the halving precedes truncation.
- Simultaneous input accept and output drain in the same cycle is legal and must not lose or duplicate a beat.

Optional Feature:
- Macro: BUTTERFLY_INVERSE_ROUND_EN.
- When defined:
  - S1 halving and S2 product truncation use round-half-up: add 1 at the dropped LSB position before the shift, on the two's complement value.
  - Saturation still applies after rounding.
- When undefined: floor truncation as above. Latency is unchanged in both cases.

Test Plan:
- W=(0x0100,0x0000), X=(0x0800,0x0600), Y=(0x0200,0x0200) -> 3 cycles later out1=(0x0500,0x0400), out2=(0x0300,0x0200).
- W=(0x0000,0x0100), X=(0x0300,0x0700), Y=(0x0700,0x0100) -> out1=(0x0500,0x0400), out2=(0x0300,0x0200).
- Negative/zero handling: X=(0x8300,0x8000), Y=(0x0100,0x0000), W=(0x0100,0) -> out1=(0x8100,0x0000), out2=(0x8200,0x0000).
- Saturation: X=(0x7F00,0), Y=(0x8000,0), W=(0x0400,0) -> out2 real=0x7FFF. Odd LSB: X real=0x0001, Y=0 -> out1 real 0x0000 (0x0001 with BUTTERFLY_INVERSE_ROUND_EN).
- Backpressure: stream 6 beats with out_ready low for cycles 4-6 -> in_ready drops, all 6 results emitted in order, no loss or duplication, outputs stable while stalled.
- Reset asserted with 2 beats in flight -> out_valid=0 next cycle, outputs 0x0000, stale beats never appear.

Source files
------------

// File: rtl/butterfly_inverse_pipe.sv
// butterfly_inverse_pipe: three-stage inverse radix-2 butterfly (IFFT, DIF).
//   out1 = (X + Y) / 2
//   out2 = ((X - Y) / 2) * conj(W)
// Data words are sign-magnitude (MSB = sign) with FRAC_W fractional bits.
// Optional build macro BUTTERFLY_INVERSE_ROUND_EN switches the halving and the
// product truncation from floor to round-half-up; latency is unaffected.
//
// Handshake: a beat moves on a rising edge when valid && ready. The whole
// pipeline advances as one (advance = in_ready = !out_valid || out_ready), so
// outputs hold while out_valid && !out_ready, and in_valid never reaches
// out_valid combinationally.
module butterfly_inverse_pipe #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] input_1_real,
  input  logic [DATA_W-1:0] input_1_imaginary,
  input  logic [DATA_W-1:0] input_2_real,
  input  logic [DATA_W-1:0] input_2_imaginary,
  input  logic [DATA_W-1:0] twiddle_real,
  input  logic [DATA_W-1:0] twiddle_imaginary,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] output_1_real,
  output logic [DATA_W-1:0] output_1_imaginary,
  output logic [DATA_W-1:0] output_2_real,
  output logic [DATA_W-1:0] output_2_imaginary
);

  // Working widths: TW holds any converted input, SW a sum/difference,
  // PW the sum of two full-precision products.
  localparam int TW = DATA_W + 1;
  localparam int SW = DATA_W + 2;
  localparam int PW = 2 * DATA_W + 3;

`ifdef BUTTERFLY_INVERSE_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

  // Largest representable magnitude, 2^(DATA_W-1)-1, at the working widths.
  localparam logic signed [TW-1:0] MAG_MAX = {2'b00, {(DATA_W-1){1'b1}}};
  localparam logic signed [PW-1:0] P_MAX   = {{(PW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [PW-1:0] P_MIN   = -P_MAX;
  localparam logic signed [PW-1:0] P_RND   = ROUND_EN ? (PW'(1) << (FRAC_W - 1)) : '0;

  // Sign-magnitude to two's complement; negative zero folds to 0.
  function automatic logic signed [TW-1:0] sm_to_tc(input logic [DATA_W-1:0] v);
    logic signed [TW-1:0] m;
    m = {2'b00, v[DATA_W-2:0]};
    return v[DATA_W-1] ? -m : m;
  endfunction

  // (a + b) / 2 or (a - b) / 2; the halving happens before any narrowing, so
  // the result always fits back into TW bits.
  function automatic logic signed [TW-1:0] halve(input logic signed [TW-1:0] a,
                                                 input logic signed [TW-1:0] b,
                                                 input logic             sub);
    logic signed [SW-1:0] s;
    if (sub) s = $signed({a[TW-1], a}) - $signed({b[TW-1], b});
    else     s = $signed({a[TW-1], a}) + $signed({b[TW-1], b});
    if (ROUND_EN) s = s + SW'(1);
    return s[TW:1];
  endfunction

  // a*b +/- c*d at full precision, scaled back by FRAC_W and clamped to the
  // representable magnitude range.
  function automatic logic signed [TW-1:0] mac(input logic signed [TW-1:0] a,
                                               input logic signed [TW-1:0] b,
                                               input logic signed [TW-1:0] c,
                                               input logic signed [TW-1:0] d,
                                               input logic             sub);
    logic signed [PW-1:0] p;
    logic signed [PW-1:0] q;
    if (sub) p = a * b - c * d;
    else     p = a * b + c * d;
    p = p + P_RND;
    q = p >>> FRAC_W;
    if (q > P_MAX)      return MAG_MAX;
    else if (q < P_MIN) return -MAG_MAX;
    else                return q[TW-1:0];
  endfunction

  // Two's complement to sign-magnitude with saturation; zero is always +0.
  function automatic logic [DATA_W-1:0] tc_to_sm(input logic signed [TW-1:0] v);
    logic [TW-1:0] mag;
    mag = v[TW-1] ? -v : v;
    if (mag > MAG_MAX)   return {v[TW-1], {(DATA_W-1){1'b1}}};
    else if (mag == '0)  return '0;
    else                 return {v[TW-1], mag[DATA_W-2:0]};
  endfunction

  logic                 v1, v2, v3;
  logic signed [TW-1:0] s1_sr, s1_si, s1_dr, s1_di, s1_wr, s1_wi;
  logic signed [TW-1:0] s2_sr, s2_si, s2_pr, s2_pi;

  assign in_ready  = !v3 || out_ready;
  assign out_valid = v3;

  // Stage valid bits: shift together on advance; reset discards in-flight beats.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else if (in_ready) begin
      v1 <= in_valid;
      v2 <= v1;
      v3 <= v2;
    end
  end

  // S1: convert inputs, register halved sum/difference and the twiddle.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_sr <= '0;
      s1_si <= '0;
      s1_dr <= '0;
      s1_di <= '0;
      s1_wr <= '0;
      s1_wi <= '0;
    end else if (in_ready) begin
      s1_sr <= halve(sm_to_tc(input_1_real),      sm_to_tc(input_2_real),      1'b0);
      s1_si <= halve(sm_to_tc(input_1_imaginary), sm_to_tc(input_2_imaginary), 1'b0);
      s1_dr <= halve(sm_to_tc(input_1_real),      sm_to_tc(input_2_real),      1'b1);
      s1_di <= halve(sm_to_tc(input_1_imaginary), sm_to_tc(input_2_imaginary), 1'b1);
      s1_wr <= sm_to_tc(twiddle_real);
      s1_wi <= sm_to_tc(twiddle_imaginary);
    end
  end

  // S2: multiply the half-difference by conj(W); pass the half-sum along.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_sr <= '0;
      s2_si <= '0;
      s2_pr <= '0;
      s2_pi <= '0;
    end else if (in_ready) begin
      s2_sr <= s1_sr;
      s2_si <= s1_si;
      s2_pr <= mac(s1_dr, s1_wr, s1_di, s1_wi, 1'b0);
      s2_pi <= mac(s1_di, s1_wr, s1_dr, s1_wi, 1'b1);
    end
  end

  // S3: sign-magnitude output registers, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      output_1_real      <= '0;
      output_1_imaginary <= '0;
      output_2_real      <= '0;
      output_2_imaginary <= '0;
    end else if (in_ready) begin
      output_1_real      <= tc_to_sm(s2_sr);
      output_1_imaginary <= tc_to_sm(s2_si);
      output_2_real      <= tc_to_sm(s2_pr);
      output_2_imaginary <= tc_to_sm(s2_pi);
    end
  end

endmodule

// File: tb/tb_butterfly_inverse_pipe.sv
// Bench for butterfly_inverse_pipe: directed spec vectors, backpressure,
// reset with beats in flight, then randomized traffic against an integer
// reference model. Honors BUTTERFLY_INVERSE_ROUND_EN for expected values.
module tb_butterfly_inverse_pipe;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;

`ifdef BUTTERFLY_INVERSE_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] x_r = '0, x_i = '0, y_r = '0, y_i = '0, w_r = '0, w_i = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] o1_r, o1_i, o2_r, o2_i;
  logic [63:0] obus;
  assign obus = {o1_r, o1_i, o2_r, o2_i};

  butterfly_inverse_pipe #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .input_1_real      (x_r),
    .input_1_imaginary (x_i),
    .input_2_real      (y_r),
    .input_2_imaginary (y_i),
    .twiddle_real      (w_r),
    .twiddle_imaginary (w_i),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .output_1_real     (o1_r),
    .output_1_imaginary(o1_i),
    .output_2_real     (o2_r),
    .output_2_imaginary(o2_i)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [63:0] exp_q[$];

  // ---------------- reference model (plain integer arithmetic) ----------------
  function automatic longint sm2i(input logic [15:0] v);
    longint mag;
    mag = longint'(v[14:0]);
    return v[15] ? -mag : mag;
  endfunction

  function automatic longint fdiv(input longint a, input longint d);
    longint q;
    q = a / d;
    if ((a % d != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic longint scale(input longint a, input longint d);
    return ROUND_EN ? fdiv(a + d / 2, d) : fdiv(a, d);
  endfunction

  function automatic logic [15:0] i2sm(input longint v);
    longint m;
    if (v > 32767)  return 16'h7FFF;
    if (v < -32767) return 16'hFFFF;
    if (v == 0)     return 16'h0000;
    m = (v < 0) ? -v : v;
    return {(v < 0), m[14:0]};
  endfunction

  function automatic logic [63:0] model(input logic [15:0] xr, xi, yr, yi, wr, wi);
    longint sr, si, dr, di, pr, pi;
    sr = scale(sm2i(xr) + sm2i(yr), 2);
    si = scale(sm2i(xi) + sm2i(yi), 2);
    dr = scale(sm2i(xr) - sm2i(yr), 2);
    di = scale(sm2i(xi) - sm2i(yi), 2);
    pr = scale(dr * sm2i(wr) + di * sm2i(wi), longint'(1) << FRAC_W);
    pi = scale(di * sm2i(wr) - dr * sm2i(wi), longint'(1) << FRAC_W);
    return {i2sm(sr), i2sm(si), i2sm(pr), i2sm(pi)};
  endfunction

  // ---------------- consumer backpressure ----------------
  int stall_lo = -1;
  int stall_hi = -1;
  bit rand_bp = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    else         out_ready = !(cyc >= stall_lo && cyc <= stall_hi);
  end

  // ---------------- scoreboard / monitor ----------------
  bit          prev_stall = 1'b0;
  bit          saw_block  = 1'b0;
  logic [64:0] held;
  always @(negedge clk) begin
    logic [63:0] e;
    #2;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (!in_ready) saw_block = 1'b1;
      if (prev_stall) begin
        assert ({out_valid, obus} === held) else begin
          miscompares++;
          $error("FAIL hold_stable got %h expected %h", {out_valid, obus}, held);
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          miscompares++;
          $error("FAIL unexpected_output got %h expected none", obus);
        end else begin
          e = exp_q.pop_front();
          assert (obus === e) else begin
            miscompares++;
            $error("FAIL result got %h expected %h", obus, e);
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      held = {out_valid, obus};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [15:0] xr, xi, yr, yi, wr, wi, input logic [63:0] exp);
    int guard;
    @(negedge clk);
    x_r = xr; x_i = xi; y_r = yr; y_i = yi; w_r = wr; w_i = wi;
    in_valid = 1'b1;
    #1;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!in_ready) begin
      miscompares++;
      $error("FAIL send_timeout got in_ready=0 expected 1 within 100 cycles");
      in_valid = 1'b0;
    end else begin
      exp_q.push_back(exp);
      vectors++;
      @(posedge clk);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  function automatic logic [15:0] rnd_data();
    logic [15:0] v;
    case ($urandom_range(0, 3))
      0:       v = 16'($urandom_range(0, 16'hFFFF));
      1:       v = {1'($urandom_range(0, 1)), 15'($urandom_range(0, 2048))};
      2:       v = {1'($urandom_range(0, 1)), 15'(16'h7FFF - $urandom_range(0, 8))};
      default: v = {1'($urandom_range(0, 1)), 15'($urandom_range(0, 1))};
    endcase
    return v;
  endfunction

  function automatic logic [15:0] rnd_tw();
    if ($urandom_range(0, 7) == 0) return 16'($urandom_range(0, 16'hFFFF));
    return {1'($urandom_range(0, 1)), 15'($urandom_range(0, 16'h0100))};
  endfunction

  task automatic send_rand();
    logic [15:0] xr, xi, yr, yi, wr, wi;
    xr = rnd_data(); xi = rnd_data(); yr = rnd_data(); yi = rnd_data();
    wr = rnd_tw();   wi = rnd_tw();
    send(xr, xi, yr, yi, wr, wi, model(xr, xi, yr, yi, wr, wi));
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    #3;
    assert (exp_q.size() == 0) else begin
      miscompares++;
      $error("FAIL drain got %0d pending expected 0", exp_q.size());
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog got no finish expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int lat;
    logic [15:0] odd;
    odd = ROUND_EN ? 16'h0001 : 16'h0000;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    assert (out_valid === 1'b0) else begin
      miscompares++; $error("FAIL reset_out_valid got %b expected 0", out_valid);
    end
    assert (obus === 64'h0) else begin
      miscompares++; $error("FAIL reset_data got %h expected 0", obus);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    assert (in_ready === 1'b1) else begin
      miscompares++; $error("FAIL in_ready_after_reset got %b expected 1", in_ready);
    end

    // first vector with latency measurement
    send(16'h0800, 16'h0600, 16'h0200, 16'h0200, 16'h0100, 16'h0000, 64'h0500_0400_0300_0200);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (lat < 10) begin
      #1;
      if (out_valid) break;
      @(negedge clk);
      lat++;
    end
    assert (lat == 3) else begin
      miscompares++; $error("FAIL latency got %0d expected 3", lat);
    end
    wait_drain();

    // remaining spec vectors streamed back to back
    send(16'h0300, 16'h0700, 16'h0700, 16'h0100, 16'h0000, 16'h0100, 64'h0500_0400_0300_0200);
    send(16'h8300, 16'h8000, 16'h0100, 16'h0000, 16'h0100, 16'h0000, 64'h8100_0000_8200_0000);
    send(16'h7F00, 16'h0000, 16'h8000, 16'h0000, 16'h0400, 16'h0000, 64'h3F80_0000_7FFF_0000);
    send(16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0000, {odd, 16'h0000, odd, 16'h0000});
    send(16'hFFFF, 16'h7FFF, 16'hFFFF, 16'h7FFF, 16'h8100, 16'h0000, 64'hFFFF_7FFF_0000_0000);
    idle();
    wait_drain();

    // backpressure: out_ready low for cycles 4..6 of a 6-beat stream
    saw_block = 1'b0;
    stall_lo = cyc + 4;
    stall_hi = cyc + 6;
    repeat (6) send_rand();
    idle();
    wait_drain();
    assert (saw_block === 1'b1) else begin
      miscompares++; $error("FAIL backpressure_in_ready got never-low expected low");
    end

    // reset with two beats in flight; a beat offered during reset is dropped
    send_rand();
    send_rand();
    @(negedge clk);
    x_r = 16'h1234;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    assert (out_valid === 1'b0) else begin
      miscompares++; $error("FAIL midreset_valid got %b expected 0", out_valid);
    end
    assert (obus === 64'h0) else begin
      miscompares++; $error("FAIL midreset_data got %h expected 0", obus);
    end
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      assert (out_valid === 1'b0) else begin
        miscompares++; $error("FAIL stale_beat got out_valid=%b expected 0", out_valid);
      end
    end

    // randomized traffic with random backpressure and input gaps
    rand_bp = 1'b1;
    for (int i = 0; i < 200; i++) begin
      send_rand();
      if ($urandom_range(0, 4) == 0) idle();
    end
    idle();
    wait_drain();
    rand_bp = 1'b0;

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
